// File: rtl/gate_reduce_pipe.sv
// Lane-wise bitwise reducer (AND/OR/XOR/NAND) with per-lane masking, a running
// accumulator and a stall-able valid/ready output pipeline STAGES registers deep.
module gate_reduce_pipe #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       lane_mask,
  input  logic [1:0]             op_sel,
  input  logic                   acc_en,
  input  logic                   acc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [WIDTH-1:0]       acc_data
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  function automatic logic [WIDTH-1:0] identity(input logic [1:0] op);
    return (op == OP_OR || op == OP_XOR) ? '0 : '1;
  endfunction

  // NAND shares the AND core; its inversion is applied only at the emit point.
  function automatic logic [WIDTH-1:0] combine(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] reduce_lanes(input logic [1:0] op,
                                                    input logic [LANES*WIDTH-1:0] data,
                                                    input logic [LANES-1:0] mask);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] lane;
    r = identity(op);
    for (int i = 0; i < LANES; i++) begin
      lane = mask[i] ? data[i*WIDTH +: WIDTH] : identity(op);
      r    = combine(op, r, lane);
    end
    return r;
  endfunction

  logic [WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]  ident;
  logic [WIDTH-1:0]  r_core;
  logic [WIDTH-1:0]  acc_base;
  logic [WIDTH-1:0]  acc_res;
  logic [WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]  pre_inv;
  logic [WIDTH-1:0]  res_emit;
  logic              advance;
  logic              accept;

  logic [STAGES-1:0] vld_p;
  logic [WIDTH-1:0]  data_p [STAGES];

  assign advance  = ~vld_p[STAGES-1] | out_ready;
  assign in_ready = advance;
  assign accept   = in_valid & advance;

  // Stage 0 input side: lane reduction and accumulator fold
  always_comb begin
    ident    = identity(op_sel);
    r_core   = reduce_lanes(op_sel, in_data, lane_mask);
    acc_base = acc_clr ? ident : acc_q;
    acc_res  = combine(op_sel, acc_base, r_core);
    acc_next = acc_q;
    pre_inv  = r_core;
    if (acc_en) begin
      acc_next = acc_res;
      pre_inv  = acc_res;
    end else if (acc_clr) begin
      acc_next = ident;
    end
    res_emit = (op_sel == OP_NAND) ? ~pre_inv : pre_inv;
  end

  // Pipeline registers p0..p(STAGES-1); the whole chain shifts together on advance
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p            <= '0;
      acc_q            <= '0;
      data_p[STAGES-1] <= '0;
    end else begin
      if (accept)
        acc_q <= acc_next;
      if (advance) begin
        vld_p[0]  <= in_valid;
        data_p[0] <= res_emit;
        for (int k = 1; k < STAGES; k++) begin
          vld_p[k]  <= vld_p[k-1];
          data_p[k] <= data_p[k-1];
        end
      end
    end
  end

  assign out_valid = vld_p[STAGES-1];
  assign out_data  = data_p[STAGES-1];
  assign acc_data  = acc_q;

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// Scoreboard bench for gate_reduce_pipe: directed beats push expected results,
// independent monitors pop and compare as each DUT presents an output.
module tb_gate_reduce_pipe;
  localparam int W = 8;
  localparam int L = 4;
  localparam logic [1:0] AND_OP = 2'b00, OR_OP = 2'b01, XOR_OP = 2'b10, NAND_OP = 2'b11;
  localparam logic [L*W-1:0] LANES_A = 32'hF03C0FFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           in_valid, v_alt;
  logic [L*W-1:0] in_data;
  logic [L-1:0]   lane_mask;
  logic [1:0]     op_sel;
  logic           acc_en, acc_clr, out_ready;
  logic           in_ready, out_valid;
  logic [W-1:0]   out_data, acc_data;
  logic           ready_alt;
  logic           in_ready_1, out_valid_1, in_ready_4, out_valid_4;
  logic [W-1:0]   out_data_1, acc_data_1, out_data_4, acc_data_4;

  gate_reduce_pipe #(.WIDTH(W), .LANES(L), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lane_mask(lane_mask), .op_sel(op_sel), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .acc_data(acc_data));

  gate_reduce_pipe #(.WIDTH(W), .LANES(L), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(v_alt), .in_ready(in_ready_1), .in_data(in_data),
    .lane_mask(lane_mask), .op_sel(op_sel), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid_1), .out_ready(ready_alt), .out_data(out_data_1), .acc_data(acc_data_1));

  gate_reduce_pipe #(.WIDTH(W), .LANES(L), .STAGES(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(v_alt), .in_ready(in_ready_4), .in_data(in_data),
    .lane_mask(lane_mask), .op_sel(op_sel), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid_4), .out_ready(ready_alt), .out_data(out_data_4), .acc_data(acc_data_4));

  typedef struct { logic [W-1:0] d; int a; } exp_t;
  exp_t q2[$], q1[$], q4[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_lat;
  bit held;
  logic [W-1:0] held_d;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got unexpected event, expected none", name);
  endtask

  // Main DUT monitor: handshakes, stall stability, in_ready during stall
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", out_data, held_d);
        held = 1'b0;
      end
      if (out_valid && !out_ready) begin
        check("in_ready_stall", in_ready, 0);
        held   = 1'b1;
        held_d = out_data;
      end else if (out_valid && out_ready) begin
        if (q2.size() == 0) fail_now("unexpected_out");
        else begin
          e = q2.pop_front();
          check("out_data", out_data, e.d);
          if (chk_lat) check("latency_s2", cyc - e.a + 1, 2);
        end
      end
    end
  end

  // STAGES=1 and STAGES=4 monitors
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (out_valid_1) begin
        if (q1.size() == 0) fail_now("unexpected_out_s1");
        else begin
          e = q1.pop_front();
          check("out_data_s1", out_data_1, e.d);
          check("latency_s1", cyc - e.a + 1, 1);
        end
      end
      if (out_valid_4) begin
        if (q4.size() == 0) fail_now("unexpected_out_s4");
        else begin
          e = q4.pop_front();
          check("out_data_s4", out_data_4, e.d);
          check("latency_s4", cyc - e.a + 1, 4);
        end
      end
    end
  end

  task automatic send(input logic [L*W-1:0] d, input logic [L-1:0] m, input logic [1:0] op,
                      input logic en, input logic clr, input logic [W-1:0] exp,
                      input bit push, input bit alt);
    int  tries;
    bit  ok;
    exp_t e;
    tries = 0;
    ok    = 1'b1;
    @(negedge clk);
    in_data = d; lane_mask = m; op_sel = op; acc_en = en; acc_clr = clr;
    in_valid = !alt; v_alt = alt;
    #2;
    while (!(alt ? (in_ready_1 && in_ready_4) : in_ready)) begin
      if (++tries > 50) begin
        check("send_timeout_in_ready", 0, 1);
        ok = 1'b0;
        break;
      end
      @(negedge clk);
      #2;
    end
    if (push && ok) begin
      e.d = exp;
      e.a = cyc + 1;
      if (alt) begin
        q1.push_back(e);
        q4.push_back(e);
      end else q2.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    v_alt    = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle();
    while ((q2.size() != 0 || q1.size() != 0 || q4.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout_pending", q2.size() + q1.size() + q4.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; v_alt = 1'b0; in_data = '0; lane_mask = '0;
    op_sel = AND_OP; acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    ready_alt = 1'b1; chk_lat = 1'b1; held = 1'b0; held_d = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 8'h00);
    check("reset_acc_data", acc_data, 8'h00);
    check("reset_in_ready", in_ready, 1);

    // Operators, masking and all-masked identities
    send(LANES_A, 4'b1111, AND_OP,  0, 0, 8'h00, 1, 0);
    send(LANES_A, 4'b0110, OR_OP,   0, 0, 8'h3F, 1, 0);
    send(LANES_A, 4'b0110, XOR_OP,  0, 0, 8'h33, 1, 0);
    send(LANES_A, 4'b0110, NAND_OP, 0, 0, 8'hF3, 1, 0);
    send(LANES_A, 4'b0000, AND_OP,  0, 0, 8'hFF, 1, 0);
    send(LANES_A, 4'b0000, OR_OP,   0, 0, 8'h00, 1, 0);
    send(LANES_A, 4'b0000, XOR_OP,  0, 0, 8'h00, 1, 0);
    send(LANES_A, 4'b0000, NAND_OP, 0, 0, 8'h00, 1, 0);
    send(LANES_A, 4'b1111, AND_OP,  0, 1, 8'h00, 1, 0);
    drain();
    check("acc_clr_only", acc_data, 8'hFF);

    // XOR accumulate
    send(32'h0000005A, 4'b0001, XOR_OP, 1, 1, 8'h5A, 1, 0);
    send(32'h000000FF, 4'b0001, XOR_OP, 1, 0, 8'hA5, 1, 0);
    drain();
    check("acc_xor", acc_data, 8'hA5);

    // Bubbles must not touch the accumulator even with acc_en/acc_clr high
    @(negedge clk);
    acc_en = 1'b1; acc_clr = 1'b1; op_sel = AND_OP; in_data = '0; lane_mask = '1;
    repeat (3) @(negedge clk);
    check("acc_bubble", acc_data, 8'hA5);

    // NAND accumulate then switch to OR on the raw accumulator
    send(32'h00003CF0, 4'b0011, NAND_OP, 1, 1, 8'hCF, 1, 0);
    send(32'h00000005, 4'b0001, OR_OP,   1, 0, 8'h35, 1, 0);
    send(LANES_A,      4'b1111, XOR_OP,  0, 0, 8'h3C, 1, 0);
    drain();
    check("acc_op_switch", acc_data, 8'h35);

    // Backpressure mid-stream
    chk_lat = 1'b0;
    fork
      begin
        for (int k = 1; k <= 6; k++)
          send({24'h0, 8'(k * 17)}, 4'b1111, XOR_OP, 0, 0, 8'(k * 17), 1, 0);
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    chk_lat = 1'b1;

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(LANES_A, 4'b1111, OR_OP, 1, 0, 8'h00, 0, 0);
    send(LANES_A, 4'b1111, OR_OP, 1, 0, 8'h00, 0, 0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_acc_data", acc_data, 8'h00);
    check("midreset_in_ready", in_ready, 1);
    repeat (6) @(negedge clk);

    // Full-rate streams on STAGES=1 and STAGES=4
    acc_en = 1'b0; acc_clr = 1'b0;
    send(32'h08040201, 4'b1111, OR_OP, 0, 0, 8'h0F, 1, 1);
    send(32'h80402010, 4'b1111, OR_OP, 0, 0, 8'hF0, 1, 1);
    send(32'h000000FF, 4'b1111, OR_OP, 0, 0, 8'hFF, 1, 1);
    send(32'h00240081, 4'b1111, OR_OP, 0, 0, 8'hA5, 1, 1);
    send(32'h00000000, 4'b1111, OR_OP, 0, 0, 8'h00, 1, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
